mer_calc_log: RTL and testbench

//  Parametrised, pipelined MER estimator: out_mer = 10*log10(mapper_power/error_power), in dB, signed fixed point.

---
 rtl/mer_calc_log_if.sv | 24 ++
 rtl/mer_calc_log.sv | 185 ++++++++++++++++++
 tb/tb_mer_calc_log.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mer_calc_log_if.sv
// Sample/result bundle between the power accumulators, the MER estimator and its consumer.
// The master drives the power sample; the slave (the estimator) returns the MER result.
interface mer_calc_log_if #(
  parameter int PWR_W = 18,
  parameter int OUT_W = 8
);
  logic                    in_valid;
  logic signed [PWR_W-1:0] mapper_power;
  logic signed [PWR_W-1:0] error_power;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_mer;
  logic                    out_err;
  logic                    out_sat;

  modport master (
    output in_valid, mapper_power, error_power,
    input  out_valid, out_mer, out_err, out_sat
  );

  modport slave (
    input  in_valid, mapper_power, error_power,
    output out_valid, out_mer, out_err, out_sat
  );
endinterface

// File: rtl/mer_calc_log.sv
// Four-stage MER estimator: 10*log10(Pm/Pe) in dB via leading-one detect, a log2 fraction LUT,
// a subtract and a fixed-point multiply by 10*log10(2); with error/saturation flags and event counters.
module mer_calc_log #(
  parameter int PWR_W  = 18,
  parameter int MANT_F = 5,
  parameter int LOG_F  = 8,
  parameter int OUT_W  = 8,
  parameter int OUT_F  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clr_stats,
  mer_calc_log_if.slave    bus,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sat_count
);

  localparam int KW     = $clog2(PWR_W);
  localparam int LG_W   = KW + LOG_F;
  localparam int D_W    = LG_W + 1;
  localparam int C_W    = LOG_F + 4;
  localparam int P_W    = D_W + C_W;
  localparam int R_W    = P_W + 1;
  localparam int SH     = 2 * LOG_F - OUT_F;
  localparam int LUT_GB = 7;

  // 10*log10(2) = 3.010299957, rounded to LOG_F fractional bits
  localparam longint unsigned C_L =
    (64'd3010299957 * (64'd1 << LOG_F) + 64'd500000000) / 64'd1000000000;
  localparam logic signed [C_W-1:0]   C_MUL = C_W'(C_L);
  localparam logic signed [R_W-1:0]   HALF  = R_W'(2 ** (SH - 1));
  localparam logic signed [R_W-1:0]   R_MAX = R_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [R_W-1:0]   R_MIN = R_W'(-(2 ** (OUT_W - 1)));
  localparam logic signed [OUT_W-1:0] O_MAX = OUT_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [OUT_W-1:0] O_MIN = OUT_W'(-(2 ** (OUT_W - 1)));

  // log2(1 + m/2^MANT_F) by repeated squaring in Q1.30, with guard bits then rounded
  function automatic logic [LOG_F-1:0] lut_val(input int m);
    longint unsigned y;
    longint unsigned frac;
    y    = 64'(2 ** MANT_F + m) << (30 - MANT_F);
    frac = 64'd0;
    for (int i = 0; i < LOG_F + LUT_GB; i++) begin
      y    = (y * y) >> 30;
      frac = frac << 1;
      if (y >= (64'd2 << 30)) begin
        frac = frac | 64'd1;
        y    = y >> 1;
      end
    end
    frac = (frac + (64'd1 << (LUT_GB - 1))) >> LUT_GB;
    if (frac >= (64'd1 << LOG_F)) lut_val = '1;
    else                          lut_val = LOG_F'(frac);
  endfunction

  function automatic logic [KW-1:0] msb_idx(input logic [PWR_W-1:0] x);
    msb_idx = '0;
    for (int i = 0; i < PWR_W - 1; i++) begin
      if (x[i]) msb_idx = KW'(i);
    end
  endfunction

  // Bits just below the leading one; zero-filled on the right when fewer than MANT_F exist
  function automatic logic [MANT_F-1:0] mant_bits(input logic [PWR_W-1:0] x,
                                                  input logic [KW-1:0]    k);
    if (int'(k) >= MANT_F) mant_bits = MANT_F'(x >> (int'(k) - MANT_F));
    else                   mant_bits = MANT_F'(x << (MANT_F - int'(k)));
  endfunction

  logic [LOG_F-1:0] lut [2**MANT_F];
  for (genvar g = 0; g < 2**MANT_F; g++) begin : g_lut
    assign lut[g] = lut_val(g);
  end

  // Control state (reset) and data lanes (no reset)
  logic v1_q, v2_q, v3_q;
  logic err1_q, err2_q, err3_q;
  logic signed [PWR_W-1:0] pm1_q, pe1_q;
  logic [KW-1:0]           k_m2_q, k_e2_q;
  logic [MANT_F-1:0]       m_m2_q, m_e2_q;
  logic signed [D_W-1:0]   d3_q;
  logic                    out_valid_q, out_err_q, out_sat_q;
  logic signed [OUT_W-1:0] out_mer_q;
  logic [CNT_W-1:0]        err_cnt_q, sat_cnt_q;

  logic [KW-1:0]           k_m_d, k_e_d;
  logic [MANT_F-1:0]       m_m_d, m_e_d;
  logic [LG_W-1:0]         lg_m, lg_e;
  logic signed [D_W-1:0]   d_d;
  logic signed [P_W-1:0]   prod;
  logic signed [R_W-1:0]   rnd;
  logic                    clip;
  logic                    out_err_d, out_sat_d;
  logic signed [OUT_W-1:0] out_mer_d;

  // NOTE: every always_comb assigns all its outputs first, so no path can infer a latch.
  always_comb begin
    k_m_d = msb_idx(pm1_q);
    k_e_d = msb_idx(pe1_q);
    m_m_d = mant_bits(pm1_q, k_m_d);
    m_e_d = mant_bits(pe1_q, k_e_d);
  end

  always_comb begin
    lg_m = {k_m2_q, lut[m_m2_q]};
    lg_e = {k_e2_q, lut[m_e2_q]};
    d_d  = $signed({1'b0, lg_m}) - $signed({1'b0, lg_e});
  end

  always_comb begin
    prod      = P_W'(d3_q) * P_W'(C_MUL);
    rnd       = (R_W'(prod) + HALF) >>> SH;
    clip      = 1'b0;
    out_mer_d = OUT_W'(rnd);
    if (rnd > R_MAX) begin
      clip      = 1'b1;
      out_mer_d = O_MAX;
    end else if (rnd < R_MIN) begin
      clip      = 1'b1;
      out_mer_d = O_MIN;
    end
    if (err3_q) out_mer_d = '1;
    out_err_d = v3_q & err3_q;
    out_sat_d = v3_q & ~err3_q & clip;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_mer_q   <= '0;
    end else if (clk_en) begin
      v1_q        <= bus.in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      out_err_q   <= out_err_d;
      out_sat_q   <= out_sat_d;
      out_mer_q   <= out_mer_d;
    end
  end

  // NOTE: data lanes carry no reset; the valid bits alone qualify them, which keeps the flops cheap.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      pm1_q  <= bus.mapper_power;
      pe1_q  <= bus.error_power;
      err1_q <= bus.mapper_power[PWR_W-1] || (bus.mapper_power == '0) ||
                bus.error_power[PWR_W-1]  || (bus.error_power == '0);
      k_m2_q <= k_m_d;
      k_e2_q <= k_e_d;
      m_m2_q <= m_m_d;
      m_e2_q <= m_e_d;
      err2_q <= err1_q;
      d3_q   <= d_d;
      err3_q <= err2_q;
    end
  end

  // Each result occupies the output register for exactly one enabled cycle, so it counts once
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      err_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else if (clk_en && out_valid_q) begin
      if (out_err_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      if (out_sat_q && (sat_cnt_q != '1)) sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mer   = out_mer_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_sat   = out_sat_q;
  assign err_count     = err_cnt_q;
  assign sat_count     = sat_cnt_q;

endmodule

// File: tb/tb_mer_calc_log.sv
// Directed bench for mer_calc_log: hand-computed dB values, latency, clipping, error samples,
// clk_en stalls, reset flush and saturating/clearable event counters.
module tb_mer_calc_log;
  localparam int PWR_W = 18;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_en;
  logic             clr_stats;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sat_count;
  int tests_run    = 0;
  int tests_failed = 0;

  mer_calc_log_if #(.PWR_W(PWR_W), .OUT_W(OUT_W)) bus ();

  mer_calc_log #(
    .PWR_W(PWR_W), .MANT_F(5), .LOG_F(8), .OUT_W(OUT_W), .OUT_F(2), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .clr_stats (clr_stats),
    .bus       (bus),
    .err_count (err_count),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int pm, input int pe);
    bus.in_valid     = v;
    bus.mapper_power = PWR_W'(pm);
    bus.error_power  = PWR_W'(pe);
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; clr_stats = 1'b0;
    drive(1'b0, 0, 0);
    repeat (2) tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
    tests_run++;
    if (bus.out_mer !== 8'sd0) begin tests_failed++; $display("FAIL reset_mer: got %0d want 0", $signed(bus.out_mer)); end
    tests_run++;
    if (bus.out_err !== 1'b0 || bus.out_sat !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got err=%0b sat=%0b want 0/0", bus.out_err, bus.out_sat);
    end
    tests_run++;
    if (err_count !== '0 || sat_count !== '0) begin
      tests_failed++; $display("FAIL reset_counts: got err=%0d sat=%0d want 0/0", err_count, sat_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    clk_en = 1'b1;
    drive(1'b1, 4096, 4096);
    tick();
    drive(1'b0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL latency_early_%0d: got valid=%0b want 0", i, bus.out_valid);
      end
      tick();
    end
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_mer !== 8'sd0 || bus.out_err !== 1'b0 || bus.out_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_equal: got v=%0b mer=%0d err=%0b sat=%0b want 1/0/0/0",
               bus.out_valid, $signed(bus.out_mer), bus.out_err, bus.out_sat);
    end
    tick();
  endtask

  // One sample, three bubbles: the result sits in the output register on return
  task automatic test_vector(input string name, input int pm, input int pe,
                             input int exp_mer, input logic exp_err, input logic exp_sat);
    clk_en = 1'b1;
    drive(1'b1, pm, pe);
    tick();
    drive(1'b0, 0, 0);
    repeat (3) tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_mer !== OUT_W'(exp_mer) ||
        bus.out_err !== exp_err || bus.out_sat !== exp_sat) begin
      tests_failed++;
      $display("FAIL %s: got v=%0b mer=%0d err=%0b sat=%0b want 1/%0d/%0b/%0b", name,
               bus.out_valid, $signed(bus.out_mer), bus.out_err, bus.out_sat, exp_mer, exp_err, exp_sat);
    end
  endtask

  task automatic test_mer_values();
    test_vector("mer_pos_18db", 4096, 64, 72, 1'b0, 1'b0);
    test_vector("mer_neg_18db", 64, 4096, -72, 1'b0, 1'b0);
    test_vector("mer_lut_1p5", 96, 64, 7, 1'b0, 1'b0);
    test_vector("mer_small_k", 3, 1, 19, 1'b0, 1'b0);
    test_vector("mer_lut_1p25", 5, 4, 4, 1'b0, 1'b0);
    test_vector("mer_neg_round", 4, 5, -4, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_sat();
    test_vector("sat_high", 4096, 1, 127, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (sat_count !== CNT_W'(1)) begin tests_failed++; $display("FAIL sat_count_1: got %0d want 1", sat_count); end
    test_vector("sat_low", 1, 4096, -128, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (sat_count !== CNT_W'(2)) begin tests_failed++; $display("FAIL sat_count_2: got %0d want 2", sat_count); end
  endtask

  task automatic test_err();
    test_vector("err_pe_zero", 4096, 0, -1, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (err_count !== CNT_W'(1)) begin tests_failed++; $display("FAIL err_count_1: got %0d want 1", err_count); end
    test_vector("err_pm_neg", -5, 64, -1, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (err_count !== CNT_W'(2) || sat_count !== CNT_W'(2)) begin
      tests_failed++; $display("FAIL err_count_2: got err=%0d sat=%0d want 2/2", err_count, sat_count);
    end
  endtask

  task automatic test_back_to_back();
    int   pm_t  [8] = '{4096, 4096, 64, 96, 3, 4096, 4096, 1};
    int   pe_t  [8] = '{4096, 64, 4096, 64, 1, 1, 0, 4096};
    int   mer_t [8] = '{0, 72, -72, 7, 19, 127, -1, -128};
    logic err_t [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic sat_t [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    for (int e = 0; e < 12; e++) begin
      logic ev;
      int   j;
      ev = (e >= 3) && (e <= 10);
      j  = ev ? e - 3 : 0;
      clk_en = 1'b1;
      if (e < 8) drive(1'b1, pm_t[e], pe_t[e]);
      else       drive(1'b0, 0, 0);
      tick();
      for (int h = 0; h < 2; h++) begin
        tests_run++;
        if (bus.out_valid !== ev ||
            (ev && (bus.out_mer !== OUT_W'(mer_t[j]) || bus.out_err !== err_t[j] || bus.out_sat !== sat_t[j])) ||
            (!ev && (bus.out_err !== 1'b0 || bus.out_sat !== 1'b0))) begin
          tests_failed++;
          $display("FAIL b2b_e%0d_%s: got v=%0b mer=%0d err=%0b sat=%0b want v=%0b mer=%0d err=%0b sat=%0b",
                   e, (h == 0) ? "en" : "hold", bus.out_valid, $signed(bus.out_mer), bus.out_err, bus.out_sat,
                   ev, ev ? mer_t[j] : 0, ev ? err_t[j] : 1'b0, ev ? sat_t[j] : 1'b0);
        end
        if (h == 0) begin
          clk_en = 1'b0;
          drive(1'b1, 0, 5);
          tick();
        end
      end
    end
    clk_en = 1'b1;
    drive(1'b0, 0, 0);
    tests_run++;
    if (err_count !== CNT_W'(3) || sat_count !== CNT_W'(4)) begin
      tests_failed++; $display("FAIL b2b_counts: got err=%0d sat=%0d want 3/4", err_count, sat_count);
    end
  endtask

  task automatic test_reset_in_flight();
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4096, 64);
      tick();
    end
    reset = 1'b1; clk_en = 1'b0;
    drive(1'b0, 0, 0);
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_mer !== 8'sd0 || bus.out_err !== 1'b0 || bus.out_sat !== 1'b0 ||
        err_count !== '0 || sat_count !== '0) begin
      tests_failed++;
      $display("FAIL flush_reset: got v=%0b mer=%0d err=%0b sat=%0b ec=%0d sc=%0d want all 0",
               bus.out_valid, $signed(bus.out_mer), bus.out_err, bus.out_sat, err_count, sat_count);
    end
    reset = 1'b0; clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL flush_bubble_%0d: got valid=%0b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_counters();
    clk_en = 1'b1;
    drive(1'b1, 4096, 0);
    repeat ((1 << CNT_W) + 2) tick();
    drive(1'b0, 0, 0);
    repeat (5) tick();
    tests_run++;
    if (err_count !== '1) begin
      tests_failed++; $display("FAIL cnt_saturate: got %0d want %0d", err_count, (1 << CNT_W) - 1);
    end
    drive(1'b1, 4096, 0);
    repeat (4) tick();
    clr_stats = 1'b1;
    tick();
    tests_run++;
    if (err_count !== '0 || sat_count !== '0) begin
      tests_failed++; $display("FAIL cnt_clear_wins: got err=%0d sat=%0d want 0/0", err_count, sat_count);
    end
    clr_stats = 1'b0;
    tick();
    tests_run++;
    if (err_count !== CNT_W'(1)) begin tests_failed++; $display("FAIL cnt_after_clear: got %0d want 1", err_count); end
    clk_en = 1'b0; clr_stats = 1'b1;
    tick();
    tests_run++;
    if (err_count !== '0) begin tests_failed++; $display("FAIL cnt_clear_no_en: got %0d want 0", err_count); end
    clr_stats = 1'b0; clk_en = 1'b1;
    drive(1'b0, 0, 0);
    repeat (5) tick();
  endtask

  initial begin
    drive(1'b0, 0, 0);
    reset = 1'b1; clk_en = 1'b0; clr_stats = 1'b0;
    test_reset();
    test_latency();
    test_mer_values();
    test_sat();
    test_err();
    test_back_to_back();
    test_reset_in_flight();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
